simmem_wburst_tracker: RTL and testbench



---
 rtl/simmem_wburst_tracker_pkg.sv | 22 ++
 rtl/simmem_wburst_tracker_if.sv | 36 +++
 rtl/simmem_wburst_fifo.sv | 66 ++++++
 rtl/simmem_wburst_tracker.sv | 120 ++++++++++++
 tb/tb_simmem_wburst_tracker.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/simmem_wburst_tracker_pkg.sv
// Shared defaults and derived widths for the write-burst tracker.
// The tracker pairs W beats with AW requests and reports completed bursts.
package simmem_wburst_tracker_pkg;

    localparam int unsigned DefaultIidWidth    = 6;
    localparam int unsigned DefaultMaxBurstLen = 16;
    localparam int unsigned DefaultAddrDepth   = 8;
    localparam int unsigned DefaultMaxOrphans  = DefaultMaxBurstLen * DefaultAddrDepth;

    // Length is encoded as beats-1, so MaxBurstLen values fit in clog2(MaxBurstLen) bits
    localparam int unsigned DefaultLenWidth    = $clog2(DefaultMaxBurstLen);
    localparam int unsigned DefaultRcvdWidth   = $clog2(DefaultMaxBurstLen + 1);
    localparam int unsigned DefaultPendWidth   = $clog2(DefaultAddrDepth + 1);
    localparam int unsigned DefaultOrphWidth   = $clog2(DefaultMaxOrphans + 1);

    // One pending write address as held in the queue
    typedef struct packed {
        logic [DefaultIidWidth-1:0] iid;
        logic [DefaultLenWidth-1:0] len;
    } wburst_entry_t;

endpackage

// File: rtl/simmem_wburst_tracker_if.sv
// Bus bundle between the AW/W snoop side, the delay calculator core and the tracker.
// The master drives snooped requests and the completion ready; the tracker is the slave.
interface simmem_wburst_tracker_if
    import simmem_wburst_tracker_pkg::*;
#(
    parameter int unsigned IidWidth  = DefaultIidWidth,
    parameter int unsigned LenWidth  = DefaultLenWidth,
    parameter int unsigned PendWidth = DefaultPendWidth,
    parameter int unsigned OrphWidth = DefaultOrphWidth
);

    logic                 waddr_valid_i;
    logic                 waddr_ready_o;
    logic [IidWidth-1:0]  waddr_iid_i;
    logic [LenWidth-1:0]  waddr_len_i;
    logic                 wdata_valid_i;
    logic                 wdata_ready_o;
    logic                 wdone_valid_o;
    logic                 wdone_ready_i;
    logic [IidWidth-1:0]  wdone_iid_o;
    logic [PendWidth-1:0] pending_cnt_o;
    logic [OrphWidth-1:0] orphan_cnt_o;

    modport master (
        output waddr_valid_i, waddr_iid_i, waddr_len_i, wdata_valid_i, wdone_ready_i,
        input  waddr_ready_o, wdata_ready_o, wdone_valid_o, wdone_iid_o,
               pending_cnt_o, orphan_cnt_o
    );

    modport slave (
        input  waddr_valid_i, waddr_iid_i, waddr_len_i, wdata_valid_i, wdone_ready_i,
        output waddr_ready_o, wdata_ready_o, wdone_valid_o, wdone_iid_o,
               pending_cnt_o, orphan_cnt_o
    );

endinterface

// File: rtl/simmem_wburst_fifo.sv
// Generic circular FIFO with registered occupancy.
// Besides the head it exposes the low PeekWidth bits of the entry behind the head,
// so the owner can prepare for the entry that a pop is about to expose.
module simmem_wburst_fifo #(
    parameter int unsigned Width     = 10,
    parameter int unsigned Depth     = 8,
    parameter int unsigned PeekWidth = Width,
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic [Width-1:0]     data_i,
    input  logic                 pop_i,
    output logic [Width-1:0]     head_o,
    output logic [PeekWidth-1:0] next_o,
    output logic [CntWidth-1:0]  count_o,
    output logic                 empty_o
);

    logic [Width-1:0]    mem_q [Depth];
    logic [PtrWidth-1:0] wr_ptr_q;
    logic [PtrWidth-1:0] rd_ptr_q;
    logic [PtrWidth-1:0] rd_next;
    logic [CntWidth-1:0] count_q;
    logic                do_push;
    logic                do_pop;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    assign do_push = push_i && (count_q != CntWidth'(Depth));
    assign do_pop  = pop_i && (count_q != '0);
    assign rd_next = ptr_inc(rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[rd_next][PeekWidth-1:0];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

    // Storage is data only; validity comes from the pointers, so it needs no reset
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers and occupancy advance on accepted pushes and pops
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_next;
            end
            count_q <= count_q + CntWidth'(do_push) - CntWidth'(do_pop);
        end
    end

endmodule

// File: rtl/simmem_wburst_tracker.sv
// Write-burst tracker: pairs W beats with AW requests in AW order and emits one
// ordered completion per burst. Beats without an address wait in an orphan counter
// and are absorbed by whichever entry next becomes head of the queue.
module simmem_wburst_tracker
    import simmem_wburst_tracker_pkg::*;
#(
    parameter int unsigned IidWidth       = DefaultIidWidth,
    parameter int unsigned MaxBurstLen    = DefaultMaxBurstLen,
    parameter int unsigned AddrDepth      = DefaultAddrDepth,
    parameter int unsigned MaxOrphanBeats = MaxBurstLen * AddrDepth
) (
    input logic clk_i,
    input logic rst_i,
    simmem_wburst_tracker_if.slave bus
);

    localparam int unsigned LenWidth   = $clog2(MaxBurstLen);
    localparam int unsigned RcvdWidth  = $clog2(MaxBurstLen + 1);
    localparam int unsigned PendWidth  = $clog2(AddrDepth + 1);
    localparam int unsigned OrphWidth  = $clog2(MaxOrphanBeats + 1);
    localparam int unsigned EntryWidth = IidWidth + LenWidth;

    logic [EntryWidth-1:0] head_entry;
    logic [LenWidth-1:0]   next_len;
    logic [PendWidth-1:0]  pending_q;
    logic                  empty;
    logic [IidWidth-1:0]   head_iid;
    logic [LenWidth-1:0]   head_len;

    logic [RcvdWidth-1:0]  rcvd_q, rcvd_d;
    logic [OrphWidth-1:0]  orphan_q, orphan_d;
    logic                  out_valid_q;
    logic [IidWidth-1:0]   out_iid_q;

    logic                  push;
    logic                  pop;
    logic                  w_hs;
    logic                  head_complete;
    logic                  to_head;
    logic                  new_head;
    logic [LenWidth-1:0]   new_len;
    logic [OrphWidth-1:0]  orphan_sum;
    logic [OrphWidth-1:0]  new_need;
    logic [OrphWidth-1:0]  take;

    simmem_wburst_fifo #(
        .Width    (EntryWidth),
        .Depth    (AddrDepth),
        .PeekWidth(LenWidth)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (push),
        .data_i ({bus.waddr_iid_i, bus.waddr_len_i}),
        .pop_i  (pop),
        .head_o (head_entry),
        .next_o (next_len),
        .count_o(pending_q),
        .empty_o(empty)
    );

    assign head_iid = head_entry[EntryWidth-1:LenWidth];
    assign head_len = head_entry[LenWidth-1:0];

    // Ready terms use registered state only, so a same-cycle pop never raises them
    assign bus.waddr_ready_o = (pending_q < PendWidth'(AddrDepth));
    assign bus.wdata_ready_o = (orphan_q != OrphWidth'(MaxOrphanBeats));
    assign bus.wdone_valid_o = out_valid_q;
    assign bus.wdone_iid_o   = out_iid_q;
    assign bus.pending_cnt_o = pending_q;
    assign bus.orphan_cnt_o  = orphan_q;

    assign push          = bus.waddr_valid_i && bus.waddr_ready_o;
    assign w_hs          = bus.wdata_valid_i && bus.wdata_ready_o;
    assign head_complete = !empty && (rcvd_q == (RcvdWidth'(head_len) + RcvdWidth'(1)));
    assign pop           = head_complete && (!out_valid_q || bus.wdone_ready_i);
    assign to_head       = !empty && !head_complete;

    // Route the beat, then let a freshly exposed head soak up as many orphans as it needs
    always_comb begin
        orphan_sum = orphan_q + OrphWidth'(w_hs && !to_head);
        rcvd_d     = rcvd_q + RcvdWidth'(w_hs && to_head);
        orphan_d   = orphan_sum;
        new_head   = pop ? ((pending_q > PendWidth'(1)) || push) : (push && empty);
        new_len    = (pop && (pending_q > PendWidth'(1))) ? next_len : bus.waddr_len_i;
        new_need   = OrphWidth'(new_len) + OrphWidth'(1);
        take       = (orphan_sum < new_need) ? orphan_sum : new_need;
        if (new_head) begin
            rcvd_d   = RcvdWidth'(take);
            orphan_d = orphan_sum - take;
        end else if (pop) begin
            rcvd_d = '0;
        end
    end

    // Head beat count and orphan pool
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rcvd_q   <= '0;
            orphan_q <= '0;
        end else begin
            rcvd_q   <= rcvd_d;
            orphan_q <= orphan_d;
        end
    end

    // One-entry completion register; held steady while the core stalls it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_iid_q   <= '0;
        end else if (pop) begin
            out_valid_q <= 1'b1;
            out_iid_q   <= head_iid;
        end else if (bus.wdone_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_simmem_wburst_tracker.sv
// Self-checking bench for simmem_wburst_tracker: directed scenarios plus random
// traffic, compared every cycle against a queue-based model of the burst rules.
module tb_simmem_wburst_tracker;
    import simmem_wburst_tracker_pkg::*;

    localparam int Depth   = DefaultAddrDepth;
    localparam int MaxOrph = DefaultMaxOrphans;

    logic clk_i = 1'b0;
    logic rst_i;

    always #5 clk_i = ~clk_i;

    simmem_wburst_tracker_if bus_if ();

    simmem_wburst_tracker dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus_if)
    );

    int errors = 0;
    int checks = 0;

    // Reference state: pending bursts, beats held by the head, orphan pool, output slot
    wburst_entry_t mq[$];
    int m_rcvd;
    int m_orphan;
    bit m_ov;
    int m_oiid;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rcvd   = 0;
        m_orphan = 0;
        m_ov     = 1'b0;
        m_oiid   = 0;
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_wdone_valid"}, int'(bus_if.wdone_valid_o), 0);
        checkOutput({tag, "_wdone_iid"},   int'(bus_if.wdone_iid_o), 0);
        checkOutput({tag, "_waddr_ready"}, int'(bus_if.waddr_ready_o), 1);
        checkOutput({tag, "_wdata_ready"}, int'(bus_if.wdata_ready_o), 1);
        checkOutput({tag, "_pending"},     int'(bus_if.pending_cnt_o), 0);
        checkOutput({tag, "_orphan"},      int'(bus_if.orphan_cnt_o), 0);
    endtask

    task automatic check_against_model();
        checkOutput("waddr_ready", int'(bus_if.waddr_ready_o), int'(mq.size() < Depth));
        checkOutput("wdata_ready", int'(bus_if.wdata_ready_o), int'(m_orphan != MaxOrph));
        checkOutput("wdone_valid", int'(bus_if.wdone_valid_o), int'(m_ov));
        checkOutput("wdone_iid",   int'(bus_if.wdone_iid_o), m_oiid);
        checkOutput("pending_cnt", int'(bus_if.pending_cnt_o), mq.size());
        checkOutput("orphan_cnt",  int'(bus_if.orphan_cnt_o), m_orphan);
    endtask

    // Advance the reference by one clock edge using the inputs applied in that cycle
    task automatic model_step(input bit awv, input int iid, input int len, input bit wv, input bit rdy);
        int sz0;
        bit aw_hs;
        bit w_hs;
        bit complete;
        bit pop;
        int take;
        wburst_entry_t e;
        sz0      = mq.size();
        aw_hs    = awv && (sz0 < Depth);
        w_hs     = wv && (m_orphan != MaxOrph);
        complete = (sz0 > 0) && (m_rcvd == int'(mq[0].len) + 1);
        pop      = complete && (!m_ov || rdy);
        if (m_ov && rdy) m_ov = 1'b0;
        if (w_hs) begin
            if (sz0 > 0 && !complete) m_rcvd++;
            else m_orphan++;
        end
        if (pop) begin
            m_ov   = 1'b1;
            m_oiid = int'(mq[0].iid);
            void'(mq.pop_front());
        end
        if (aw_hs) begin
            e.iid = DefaultIidWidth'(iid);
            e.len = DefaultLenWidth'(len);
            mq.push_back(e);
        end
        if ((pop && mq.size() > 0) || (!pop && sz0 == 0 && aw_hs)) begin
            take = (m_orphan < int'(mq[0].len) + 1) ? m_orphan : int'(mq[0].len) + 1;
            m_rcvd   = take;
            m_orphan = m_orphan - take;
        end else if (pop) begin
            m_rcvd = 0;
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check, then clock both DUT and model
    task automatic applyStimulus(input bit awv, input int iid, input int len, input bit wv, input bit rdy);
        bus_if.waddr_valid_i = awv;
        bus_if.waddr_iid_i   = DefaultIidWidth'(iid);
        bus_if.waddr_len_i   = DefaultLenWidth'(len);
        bus_if.wdata_valid_i = wv;
        bus_if.wdone_ready_i = rdy;
        check_against_model();
        @(posedge clk_i);
        model_step(awv, iid, len, wv, rdy);
        @(negedge clk_i);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 1'b0, rdy);
    endtask

    task automatic beats(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 1'b1, rdy);
    endtask

    // Reset asserted between edges; outputs must clear without any clock
    task automatic async_reset(input string tag);
        #2;
        rst_i = 1'b1;
        #1;
        check_reset_values(tag);
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i                = 1'b1;
        bus_if.waddr_valid_i = 1'b0;
        bus_if.waddr_iid_i   = '0;
        bus_if.waddr_len_i   = '0;
        bus_if.wdata_valid_i = 1'b0;
        bus_if.wdone_ready_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        check_reset_values("por");
        rst_i = 1'b0;

        $display("[TB] plain burst");
        applyStimulus(1'b1, 3, 3, 1'b0, 1'b1);
        beats(4, 1'b1);
        checkOutput("plain_n1_valid", int'(bus_if.wdone_valid_o), 0);
        idle(1, 1'b1);
        checkOutput("plain_n2_valid", int'(bus_if.wdone_valid_o), 1);
        checkOutput("plain_n2_iid", int'(bus_if.wdone_iid_o), 3);
        idle(1, 1'b1);
        checkOutput("plain_n3_valid", int'(bus_if.wdone_valid_o), 0);
        checkOutput("plain_pending", int'(bus_if.pending_cnt_o), 0);

        $display("[TB] data before address");
        async_reset("rst_a");
        beats(6, 1'b1);
        checkOutput("orphan_6", int'(bus_if.orphan_cnt_o), 6);
        applyStimulus(1'b1, 1, 1, 1'b0, 1'b1);
        applyStimulus(1'b1, 2, 3, 1'b0, 1'b1);
        checkOutput("dba_first_iid", int'(bus_if.wdone_iid_o), 1);
        checkOutput("dba_first_valid", int'(bus_if.wdone_valid_o), 1);
        idle(1, 1'b1);
        checkOutput("dba_second_iid", int'(bus_if.wdone_iid_o), 2);
        checkOutput("dba_second_valid", int'(bus_if.wdone_valid_o), 1);
        checkOutput("dba_orphan", int'(bus_if.orphan_cnt_o), 0);

        $display("[TB] saturation");
        async_reset("rst_b");
        beats(130, 1'b1);
        checkOutput("sat_wready", int'(bus_if.wdata_ready_o), 0);
        checkOutput("sat_orphan", int'(bus_if.orphan_cnt_o), 128);
        applyStimulus(1'b1, 7, 15, 1'b0, 1'b1);
        checkOutput("sat_release_wready", int'(bus_if.wdata_ready_o), 1);
        checkOutput("sat_release_orphan", int'(bus_if.orphan_cnt_o), 112);
        idle(3, 1'b1);

        $display("[TB] stall");
        async_reset("rst_c");
        applyStimulus(1'b1, 4, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 6, 0, 1'b0, 1'b0);
        beats(4, 1'b0);
        idle(2, 1'b0);
        checkOutput("stall_iid", int'(bus_if.wdone_iid_o), 4);
        checkOutput("stall_valid", int'(bus_if.wdone_valid_o), 1);
        checkOutput("stall_orphan", int'(bus_if.orphan_cnt_o), 2);
        idle(1, 1'b1);
        checkOutput("stall_order_5", int'(bus_if.wdone_iid_o), 5);
        idle(1, 1'b1);
        checkOutput("stall_order_6", int'(bus_if.wdone_iid_o), 6);
        idle(1, 1'b1);
        checkOutput("stall_drained", int'(bus_if.wdone_valid_o), 0);

        $display("[TB] same-cycle absorption");
        async_reset("rst_d");
        beats(3, 1'b1);
        applyStimulus(1'b1, 9, 3, 1'b1, 1'b1);
        checkOutput("abs_orphan", int'(bus_if.orphan_cnt_o), 0);
        checkOutput("abs_n1_valid", int'(bus_if.wdone_valid_o), 0);
        idle(1, 1'b1);
        checkOutput("abs_n2_valid", int'(bus_if.wdone_valid_o), 1);
        checkOutput("abs_n2_iid", int'(bus_if.wdone_iid_o), 9);

        $display("[TB] reset mid-burst and full queue");
        applyStimulus(1'b1, 11, 7, 1'b0, 1'b1);
        beats(2, 1'b1);
        async_reset("rst_mid");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 20 + i, 2, 1'b0, 1'b0);
        checkOutput("full_wready", int'(bus_if.waddr_ready_o), 0);
        checkOutput("full_pending", int'(bus_if.pending_cnt_o), 8);
        applyStimulus(1'b1, 40, 2, 1'b0, 1'b0);
        checkOutput("full_blocked", int'(bus_if.pending_cnt_o), 8);

        $display("[TB] random traffic");
        async_reset("rst_e");
        for (int ph = 0; ph < 4; ph++) begin
            int paw;
            int pw;
            int prdy;
            paw  = (ph == 0) ? 30 : (ph == 1) ? 5  : (ph == 2) ? 60 : 20;
            pw   = (ph == 0) ? 70 : (ph == 1) ? 90 : (ph == 2) ? 40 : 60;
            prdy = (ph == 0) ? 90 : (ph == 1) ? 50 : (ph == 2) ? 20 : 70;
            for (int c = 0; c < 600; c++) begin
                if ($urandom_range(0, 199) == 0) begin
                    async_reset("rst_rand");
                end
                applyStimulus(int'($urandom_range(0, 99)) < paw,
                              int'($urandom_range(0, 63)),
                              int'($urandom_range(0, 15)),
                              int'($urandom_range(0, 99)) < pw,
                              int'($urandom_range(0, 99)) < prdy);
            end
        end
        idle(40, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
